// File: rtl/main_mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single main-memory port.
// Round-robin on ties; each grant lasts at least two cycles and ends in a one-cycle DONE handshake.
//   state   | meaning
//   IDLE    | no grant; requests sampled at each posedge
//   GRANT_I | I-cache owns memory (block read)
//   GRANT_D | D-cache owns memory (read, or write-back when DC_WRITE)
//   DONE    | owner's busywait released for one cycle; next decision at its end
module main_mem_arbiter (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IC_READ,
  input  logic [27:0]  IC_ADDRESS,
  output logic [127:0] IC_READDATA,
  output logic         IC_BUSYWAIT,
  input  logic         DC_READ,
  input  logic         DC_WRITE,
  input  logic [27:0]  DC_ADDRESS,
  input  logic [127:0] DC_WRITEDATA,
  output logic [127:0] DC_READDATA,
  output logic         DC_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t       state, state_nxt;
  logic         owner, owner_nxt;
  logic         last_grant, last_grant_nxt;
  logic         started;
  logic [27:0]  addr_q;
  logic [127:0] wdata_q;
  logic         ic_pend, dc_pend, in_grant, complete;

  always_comb begin
    ic_pend        = IC_READ;
    dc_pend        = DC_READ | DC_WRITE;
    in_grant       = (state == GRANT_I) || (state == GRANT_D);
    complete       = in_grant && started && !MEM_BUSYWAIT;
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = addr_q;
    MEM_WRITEDATA  = wdata_q;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        // on a tie the side that did not win last time is served
        if (ic_pend && (!dc_pend || last_grant)) begin
          state_nxt      = GRANT_I;
          owner_nxt      = 1'b0;
          last_grant_nxt = 1'b0;
        end else if (dc_pend) begin
          state_nxt      = GRANT_D;
          owner_nxt      = 1'b1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT_I: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = IC_ADDRESS;
        if (complete) state_nxt = DONE;
      end
      GRANT_D: begin
        MEM_ADDRESS   = DC_ADDRESS;
        MEM_WRITEDATA = DC_WRITEDATA;
        MEM_WRITE     = DC_WRITE;
        MEM_READ      = !DC_WRITE;
        if (complete) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign IC_BUSYWAIT = !RESET && ic_pend && !((state == DONE) && !owner);
  assign DC_BUSYWAIT = !RESET && dc_pend && !((state == DONE) && owner);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b0;
      started     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      IC_READDATA <= '0;
      DC_READDATA <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      // memory busywait is only meaningful from the second grant cycle on
      started    <= in_grant && (state_nxt == state);
      if (in_grant) begin
        addr_q  <= MEM_ADDRESS;
        wdata_q <= MEM_WRITEDATA;
      end
      if (complete && MEM_READ) begin
        if (owner) DC_READDATA <= MEM_READDATA;
        else       IC_READDATA <= MEM_READDATA;
      end
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: vector table, directed corner sequences and random traffic
// checked every cycle against a transaction-level reference model.
module tb_main_mem_arbiter;

  logic         CLK, RESET;
  logic         IC_READ, DC_READ, DC_WRITE, MEM_BUSYWAIT;
  logic [27:0]  IC_ADDRESS, DC_ADDRESS;
  logic [127:0] DC_WRITEDATA, MEM_READDATA;
  logic [127:0] IC_READDATA, DC_READDATA, MEM_WRITEDATA;
  logic         IC_BUSYWAIT, DC_BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;

  int errors = 0;
  int checks = 0;

  main_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .IC_READ(IC_READ), .IC_ADDRESS(IC_ADDRESS), .IC_READDATA(IC_READDATA), .IC_BUSYWAIT(IC_BUSYWAIT),
    .DC_READ(DC_READ), .DC_WRITE(DC_WRITE), .DC_ADDRESS(DC_ADDRESS), .DC_WRITEDATA(DC_WRITEDATA),
    .DC_READDATA(DC_READDATA), .DC_BUSYWAIT(DC_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: phase 0 idle, 1 owning memory, 2 done handshake
  int           m_phase = 0;
  int           m_age = 0;
  logic         m_side = 1'b0;
  logic         m_last = 1'b0;
  logic [27:0]  m_addr = '0;
  logic [127:0] m_wd = '0, m_icd = '0, m_dcd = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic grant, done, e_rd, e_wr;
    grant = (m_phase == 1);
    done  = (m_phase == 2);
    e_rd  = grant && (!m_side || !DC_WRITE);
    e_wr  = grant && m_side && DC_WRITE;
    chk("mem_read", 128'(MEM_READ), 128'(e_rd));
    chk("mem_write", 128'(MEM_WRITE), 128'(e_wr));
    chk("mem_address", 128'(MEM_ADDRESS), 128'(grant ? (m_side ? DC_ADDRESS : IC_ADDRESS) : m_addr));
    chk("mem_writedata", MEM_WRITEDATA, (grant && m_side) ? DC_WRITEDATA : m_wd);
    chk("ic_busywait", 128'(IC_BUSYWAIT), 128'(!RESET && IC_READ && !(done && !m_side)));
    chk("dc_busywait", 128'(DC_BUSYWAIT), 128'(!RESET && (DC_READ || DC_WRITE) && !(done && m_side)));
    chk("ic_readdata", IC_READDATA, m_icd);
    chk("dc_readdata", DC_READDATA, m_dcd);
  endtask

  task automatic model_update();
    logic pi, pd;
    if (RESET) begin
      m_phase = 0; m_age = 0; m_side = 1'b0; m_last = 1'b0;
      m_addr = '0; m_wd = '0; m_icd = '0; m_dcd = '0;
    end else if (m_phase == 1) begin
      m_addr = m_side ? DC_ADDRESS : IC_ADDRESS;
      if (m_side) m_wd = DC_WRITEDATA;
      if (m_age >= 1 && !MEM_BUSYWAIT) begin
        if (!m_side) m_icd = MEM_READDATA;
        else if (!DC_WRITE) m_dcd = MEM_READDATA;
        m_phase = 2;
      end
      m_age++;
    end else begin
      pi = IC_READ;
      pd = DC_READ || DC_WRITE;
      if (pi || pd) begin
        m_side  = (pi && pd) ? !m_last : pd;
        m_last  = m_side;
        m_phase = 1;
        m_age   = 0;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  // called 1 time unit after a posedge: check at the negedge, then advance one clock
  task automatic half();
    #4 check_model();
  endtask

  task automatic edge_();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic step();
    half();
    edge_();
  endtask

  task automatic clear_inputs();
    IC_READ = 1'b0; DC_READ = 1'b0; DC_WRITE = 1'b0; MEM_BUSYWAIT = 1'b0;
    IC_ADDRESS = 28'h0000010; DC_ADDRESS = 28'h0000020;
    DC_WRITEDATA = '0; MEM_READDATA = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  typedef struct {
    logic ic, dr, dw, busy;
    logic [127:0] rdata;
    logic e_rd, e_wr, e_icbw, e_dcbw;
    logic [27:0] e_addr;
    logic [127:0] e_icrd, e_dcrd;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] D1 = {4{32'hD1D1_0001}};
  localparam logic [127:0] D2 = {4{32'hD2D2_0002}};
  localparam logic [127:0] D3 = {4{32'hD3D3_0003}};

  vec_t tbl[12];
  int   side_q[$];

  initial begin
    tbl[0]  = '{H, H, L, H, Z,  L, L, H, H, 28'h00, Z,  Z};
    tbl[1]  = '{H, H, L, L, Z,  H, L, H, H, 28'h20, Z,  Z};
    tbl[2]  = '{H, H, L, L, D1, H, L, H, H, 28'h20, Z,  Z};
    tbl[3]  = '{H, H, L, H, Z,  L, L, H, L, 28'h20, Z,  D1};
    tbl[4]  = '{H, H, L, H, Z,  H, L, H, H, 28'h10, Z,  D1};
    tbl[5]  = '{H, H, L, H, Z,  H, L, H, H, 28'h10, Z,  D1};
    tbl[6]  = '{H, H, L, L, D2, H, L, H, H, 28'h10, Z,  D1};
    tbl[7]  = '{H, H, L, H, Z,  L, L, L, H, 28'h10, D2, D1};
    tbl[8]  = '{L, L, L, H, Z,  H, L, L, L, 28'h20, D2, D1};
    tbl[9]  = '{L, L, L, L, D3, H, L, L, L, 28'h20, D2, D1};
    tbl[10] = '{L, L, L, H, Z,  L, L, L, L, 28'h20, D2, D3};
    tbl[11] = '{L, L, L, H, Z,  L, L, L, L, 28'h20, D2, D3};

    clear_inputs();
    RESET = 1'b1;
    @(posedge CLK);
    model_update();
    #1;
    IC_READ = 1'b1; DC_READ = 1'b1;
    step();
    chk("reset_ic_busywait", 128'(IC_BUSYWAIT), 128'(0));
    chk("reset_mem_address", 128'(MEM_ADDRESS), 128'(0));
    do_reset();

    // tie from reset goes to D, then alternates; dropped request does not abort its grant
    for (int i = 0; i < 12; i++) begin
      IC_READ = tbl[i].ic; DC_READ = tbl[i].dr; DC_WRITE = tbl[i].dw;
      MEM_BUSYWAIT = tbl[i].busy; MEM_READDATA = tbl[i].rdata;
      half();
      chk($sformatf("tbl%0d_mem_read", i), 128'(MEM_READ), 128'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_mem_write", i), 128'(MEM_WRITE), 128'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_ic_bw", i), 128'(IC_BUSYWAIT), 128'(tbl[i].e_icbw));
      chk($sformatf("tbl%0d_dc_bw", i), 128'(DC_BUSYWAIT), 128'(tbl[i].e_dcbw));
      chk($sformatf("tbl%0d_addr", i), 128'(MEM_ADDRESS), 128'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_ic_rd", i), IC_READDATA, tbl[i].e_icrd);
      chk($sformatf("tbl%0d_dc_rd", i), DC_READDATA, tbl[i].e_dcrd);
      edge_();
    end

    // I-cache fetch with memory busy for three grant cycles
    do_reset();
    IC_READ = 1'b1; MEM_BUSYWAIT = 1'b1; MEM_READDATA = {8{16'hAAAA}};
    repeat (4) step();
    MEM_BUSYWAIT = 1'b0;
    step();
    chk("icfetch_data", IC_READDATA, {8{16'hAAAA}});
    chk("icfetch_bw_done", 128'(IC_BUSYWAIT), 128'(0));
    IC_READ = 1'b0;
    step();

    // D-cache write-back
    DC_WRITE = 1'b1; DC_ADDRESS = 28'h0000020; DC_WRITEDATA = {8{16'h1234}};
    step();
    chk("wb_mem_write", 128'(MEM_WRITE), 128'(1));
    chk("wb_mem_read", 128'(MEM_READ), 128'(0));
    chk("wb_writedata", MEM_WRITEDATA, {8{16'h1234}});
    step();
    step();
    chk("wb_dc_bw_done", 128'(DC_BUSYWAIT), 128'(0));
    chk("wb_dc_readdata", DC_READDATA, Z);
    DC_WRITE = 1'b0;
    step();

    // write wins over read
    DC_READ = 1'b1; DC_WRITE = 1'b1;
    step();
    chk("rw_mem_write", 128'(MEM_WRITE), 128'(1));
    chk("rw_mem_read", 128'(MEM_READ), 128'(0));
    step();
    step();
    DC_READ = 1'b0; DC_WRITE = 1'b0;
    step();

    // reset in the second GRANT_I cycle abandons the fetch
    IC_READ = 1'b1; MEM_BUSYWAIT = 1'b1; MEM_READDATA = {8{16'h7777}};
    step();
    step();
    RESET = 1'b1;
    step();
    chk("rst_mid_mem_read", 128'(MEM_READ), 128'(0));
    chk("rst_mid_ic_rd", IC_READDATA, Z);
    RESET = 1'b0; IC_READ = 1'b0; MEM_BUSYWAIT = 1'b0;
    step();

    // request dropped after the grant still completes and captures
    IC_READ = 1'b1; MEM_READDATA = {8{16'h5555}};
    step();
    IC_READ = 1'b0;
    step();
    step();
    chk("drop_ic_rd", IC_READDATA, {8{16'h5555}});
    step();

    // continuous requests from both sides alternate D, I, D, I, ...
    do_reset();
    IC_READ = 1'b1; DC_READ = 1'b1;
    begin
      logic prev_active = 1'b0;
      for (int c = 0; c < 60 && side_q.size() < 6; c++) begin
        step();
        if ((MEM_READ || MEM_WRITE) && !prev_active) side_q.push_back(MEM_ADDRESS == 28'h20 ? 1 : 0);
        prev_active = MEM_READ || MEM_WRITE;
      end
    end
    chk("rr_grant_count", 128'(side_q.size() >= 6), 128'(1));
    foreach (side_q[k]) chk($sformatf("rr_side%0d", k), 128'(side_q[k]), 128'((k % 2 == 0) ? 1 : 0));
    clear_inputs();
    step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      RESET = ($urandom_range(79) == 0);
      if ($urandom_range(3) == 0) IC_READ = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) DC_READ = 1'($urandom_range(1));
      if ($urandom_range(5) == 0) DC_WRITE = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) IC_ADDRESS = 28'($urandom);
      if ($urandom_range(3) == 0) DC_ADDRESS = 28'($urandom);
      DC_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      MEM_BUSYWAIT = 1'($urandom_range(1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
